// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a small circular return-address stack.
// Each cycle the PC holds, returns, calls, jumps or steps sequentially.
// Priority: stall, then ret, then call, then jump, then sequential.
// A call on a full stack overwrites the oldest entry.
module pc_sequencer #(
  parameter int                 ADDR_W     = 32,
  parameter int                 STEP       = 4,
  parameter int                 RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           jump_en,
  input  logic                           call_en,
  input  logic                           ret_en,
  input  logic                           rel,
  input  logic [ADDR_W-1:0]              target,
  output logic [ADDR_W-1:0]              pc,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
  localparam logic [CNT_W-1:0]  DEPTH_V = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [PTR_W-1:0]  sp_reg, sp_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;
  logic              push;
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] tgt_addr;

  // Stack storage; sp_reg points at the top entry. Being circular, a push
  // onto a full stack lands on the slot holding the oldest entry.
  logic [ADDR_W-1:0] stack_mem [RAS_DEPTH];

  assign seq_addr = pc_reg + STEP_V;
  assign tgt_addr = rel ? (pc_reg + target) : target;

  // Next-state selection following the control priority order
  always_comb begin
    pc_next    = pc_reg;
    sp_next    = sp_reg;
    count_next = count_reg;
    ovf_next   = 1'b0;
    unf_next   = 1'b0;
    push       = 1'b0;
    if (stall) begin
      // hold everything; pulses drop to zero
    end else if (ret_en) begin
      if (count_reg != '0) begin
        pc_next    = stack_mem[sp_reg];
        sp_next    = sp_reg - 1'b1;
        count_next = count_reg - 1'b1;
      end else begin
        pc_next  = seq_addr;
        unf_next = 1'b1;
      end
    end else if (call_en) begin
      pc_next = tgt_addr;
      push    = 1'b1;
      sp_next = sp_reg + 1'b1;
      if (count_reg == DEPTH_V) begin
        ovf_next = 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end else if (jump_en) begin
      pc_next = tgt_addr;
    end else begin
      pc_next = seq_addr;
    end
  end

  // Architectural state with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= RESET_ADDR;
      sp_reg    <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      sp_reg    <= sp_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Stack write; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack_mem[sp_next] <= seq_addr;
    end
  end

  assign pc        = pc_reg;
  assign ras_count = count_reg;
  assign ras_ovf   = ovf_reg;
  assign ras_unf   = unf_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, jump_en, call_en, ret_en, rel;
  logic [31:0] target;
  logic [31:0] pc;
  logic [2:0]  ras_count;
  logic        ras_ovf, ras_unf;

  int n_vec  = 0;
  int n_miss = 0;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .jump_en   (jump_en),
    .call_en   (call_en),
    .ret_en    (ret_en),
    .rel       (rel),
    .target    (target),
    .pc        (pc),
    .ras_count (ras_count),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Drive controls for the next edge
  task automatic drive(input logic s, input logic r, input logic c, input logic j,
                       input logic rl, input logic [31:0] t);
    stall = s; ret_en = r; call_en = c; jump_en = j; rel = rl; target = t;
  endtask

  // Advance one edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full observable state
  task automatic expect_state(input string tag, input logic [31:0] epc,
                              input logic [2:0] ecnt, input logic eovf, input logic eunf);
    check({tag, ".pc"},  64'(pc),        64'(epc));
    check({tag, ".cnt"}, 64'(ras_count), 64'(ecnt));
    check({tag, ".ovf"}, 64'(ras_ovf),   64'(eovf));
    check({tag, ".unf"}, 64'(ras_unf),   64'(eunf));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0);
    #12;
    expect_state("reset", 32'h0, 3'd0, 0, 0);
    reset = 1'b0;

    // Idle stepping from reset
    step(); expect_state("idle1", 32'h4, 3'd0, 0, 0);
    step(); check("idle2.pc", 64'(pc), 64'h8);
    step(); expect_state("idle3", 32'hC, 3'd0, 0, 0);

    // Call and return
    drive(0, 0, 0, 1, 0, 32'h100); step(); check("jmp100.pc", 64'(pc), 64'h100);
    drive(0, 0, 1, 0, 0, 32'h400); step(); expect_state("call400", 32'h400, 3'd1, 0, 0);
    drive(0, 1, 0, 0, 0, 32'h0);   step(); expect_state("ret104", 32'h104, 3'd0, 0, 0);

    // Relative jump with negative offset, and PC wrap
    drive(0, 0, 0, 1, 0, 32'h200);      step(); check("jmp200.pc", 64'(pc), 64'h200);
    drive(0, 0, 0, 1, 1, 32'hFFFFFFF0); step(); expect_state("reljmp", 32'h1F0, 3'd0, 0, 0);
    drive(0, 0, 0, 1, 0, 32'hFFFFFFFC); step(); check("jmpmax.pc", 64'(pc), 64'hFFFFFFFC);
    drive(0, 0, 0, 0, 0, 32'h0);        step(); check("wrap.pc", 64'(pc), 64'h0);

    // Five calls overflow a four-entry stack
    drive(0, 0, 0, 1, 0, 32'h10); step(); check("jmp10.pc", 64'(pc), 64'h10);
    drive(0, 0, 1, 0, 0, 32'h20); step(); expect_state("call1", 32'h20, 3'd1, 0, 0);
    drive(0, 0, 1, 0, 0, 32'h30); step(); expect_state("call2", 32'h30, 3'd2, 0, 0);
    drive(0, 0, 1, 0, 0, 32'h40); step(); expect_state("call3", 32'h40, 3'd3, 0, 0);
    drive(0, 0, 1, 0, 0, 32'h50); step(); expect_state("call4", 32'h50, 3'd4, 0, 0);
    drive(0, 0, 1, 0, 0, 32'h60); step(); expect_state("call5", 32'h60, 3'd4, 1, 0);
    drive(0, 1, 0, 0, 0, 32'h0);
    step(); expect_state("ret1", 32'h54, 3'd3, 0, 0);
    step(); expect_state("ret2", 32'h44, 3'd2, 0, 0);
    step(); expect_state("ret3", 32'h34, 3'd1, 0, 0);
    step(); expect_state("ret4", 32'h24, 3'd0, 0, 0);
    step(); expect_state("ret5", 32'h28, 3'd0, 0, 1);
    drive(0, 0, 0, 0, 0, 32'h0);
    step(); expect_state("postunf", 32'h2C, 3'd0, 0, 0);

    // ret wins over call and jump
    drive(0, 0, 0, 1, 0, 32'h7C);  step(); check("jmp7c.pc", 64'(pc), 64'h7C);
    drive(0, 0, 1, 0, 0, 32'h300); step(); expect_state("call300", 32'h300, 3'd1, 0, 0);
    drive(0, 1, 1, 1, 0, 32'h500); step(); expect_state("retwins", 32'h80, 3'd0, 0, 0);
    drive(0, 1, 0, 0, 0, 32'h0);   step(); expect_state("nopush", 32'h84, 3'd0, 0, 1);

    // Stall holds state and clears pulses
    drive(1, 0, 0, 1, 0, 32'h900); step(); expect_state("stalljmp", 32'h84, 3'd0, 0, 0);
    drive(1, 0, 1, 0, 0, 32'h900); step(); expect_state("stallcall", 32'h84, 3'd0, 0, 0);

    // Asynchronous reset during a call
    drive(0, 0, 1, 0, 0, 32'h1000); step(); expect_state("call1000", 32'h1000, 3'd1, 0, 0);
    drive(0, 0, 1, 0, 0, 32'h2000);
    #3 reset = 1'b1;
    #1 expect_state("asyncrst", 32'h0, 3'd0, 0, 0);
    step(); expect_state("rsthold", 32'h0, 3'd0, 0, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    step(); expect_state("postrst", 32'h4, 3'd0, 0, 0);
    drive(0, 1, 0, 0, 0, 32'h0);
    step(); expect_state("postrstret", 32'h8, 3'd0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and target width in bits (>= 8).
REQ-002 SHALL have parameter STEP, default 4, sequential increment in bytes.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >= 2).
REQ-004 SHALL have parameter RESET_ADDR, default 0, PC value loaded on reset.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port stall  input  1  hold all state this cycle.
REQ-008 SHALL have port jump_en  input  1  redirect PC to computed target.
REQ-009 SHALL have port call_en  input  1  redirect to target and push return address.
REQ-010 SHALL have port ret_en  input  1  pop return address into PC.
REQ-011 SHALL have port rel  input  1  target mode: 0 absolute, 1 PC-relative.
REQ-012 SHALL have port target  input  ADDR_W  absolute address, or two's-complement offset when rel=1.
REQ-013 SHALL have port pc  output  ADDR_W  current program counter (registered).
REQ-014 SHALL have port ras_count  output  $clog2(RAS_DEPTH)+1  number of valid stack entries.
REQ-015 SHALL have port ras_ovf  output  1  one-cycle pulse: push onto full stack.
REQ-016 SHALL have port ras_unf  output  1  one-cycle pulse: pop from empty stack.

Function
REQ-017 SHALL compute tgt = rel ? pc + target : target, modulo 2^ADDR_W.
REQ-018 SHALL compute seq = pc + STEP, modulo 2^ADDR_W (wrap from max to low addresses, no flag).
REQ-019 SHALL apply per-cycle priority: stall > ret_en > call_en > jump_en > sequential.
REQ-020 stall=1: pc, stack, ras_count held; ras_ovf and ras_unf driven 0 that cycle.
REQ-021 Sequential (no control asserted): pc <= seq.
REQ-022 jump_en only: pc <= tgt; stack unchanged.
REQ-023 call_en (ret_en=0): pc <= tgt; push seq; ras_count increments, saturating at RAS_DEPTH.
REQ-024 call on full stack: oldest entry discarded, new entry becomes top, ras_count stays RAS_DEPTH, ras_ovf=1 next cycle.
REQ-025 ret_en with ras_count>0: pc <= top entry; entry removed; ras_count decrements.
REQ-026 ret_en with ras_count=0: pc <= seq; ras_count stays 0; ras_unf=1 next cycle.
REQ-027 ret_en together with call_en and/or jump_en: ret only; call/jump ignored, no push.
REQ-028 ras_ovf and ras_unf SHALL be registered, high exactly one cycle per event, otherwise 0.
REQ-029 Stack SHALL be LIFO; after an overflow the surviving entries pop in most-recent-first order.
REQ-030 pc SHALL change only on clk rising edge or reset; no combinational path from inputs to pc.

Reset
REQ-031 reset=1 SHALL immediately force pc=RESET_ADDR, ras_count=0, ras_ovf=0, ras_unf=0, independent of clk.
REQ-032 While reset=1, all inputs SHALL be ignored; stack contents are don't-care but unreachable (count 0).
REQ-033 First edge after reset deasserts: normal priority applies (e.g. idle -> pc=RESET_ADDR+STEP).
REQ-034 Reset asserted mid-call/ret SHALL discard the operation; no partial push or pop observable.

Verification
REQ-035 Reset then 3 idle cycles (defaults) -> pc 0, 4, 8, 12; ras_count 0.
REQ-036 pc=0x100, call_en, rel=0, target=0x400 -> pc=0x400, ras_count=1; next ret_en -> pc=0x104, ras_count=0.
REQ-037 pc=0x200, jump_en, rel=1, target=0xFFFFFFF0 -> pc=0x1F0; pc=0xFFFFFFFC idle -> pc=0x0.
REQ-038 Five calls from pc 0x10,0x20,0x30,0x40,0x50 (targets = next) -> fifth cycle ras_ovf=1, count 4; four rets -> 0x54,0x44,0x34,0x24; fifth ret -> ras_unf=1, pc=seq.
REQ-039 call_en+ret_en together with count=1, top=0x80 -> pc=0x80, count 0, no push; stall=1 with jump_en -> pc unchanged, no pulses.
REQ-040 reset asserted asynchronously between edges during call -> pc=RESET_ADDR at once, ras_count=0, no ras_ovf.
